aes_word_loader: RTL and testbench
==================================

Name: aes_word_loader

Overview:
- Upstream front-end for the combinational AES-128 encryption core.
- Accepts a 32-bit word stream with valid/ready and assembles it into 128-bit key and 128-bit plaintext blocks.
- Presents each completed block, together with its key, on a registered 128-bit valid/ready interface that drives the core's data and key inputs.
- Supports back-to-back blocks and in-stream key updates without corrupting a block already in flight.

Parameters:
- CNT_W, 16, width of the completed-block counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous assert, active-low.
- s_data  input  32  input word; first word of a group = bits [127:96].
- s_is_key  input  1  1 = word belongs to a key group, 0 = plaintext group; sampled with s_valid.
- s_valid  input  1  input word valid.
- s_ready  output  1  loader accepts s_data this cycle.
- m_block  output  128  assembled plaintext, to core data input.
- m_key  output  128  key bound to m_block, to core key input.
- m_valid  output  1  m_block/m_key hold a block.
- m_ready  input  1  downstream consumes the block.
- key_loaded  output  1  at least one full key captured since reset.
- err  output  1  one-cycle pulse on group-type switch mid-group.
- blk_count  output  CNT_W  blocks handed off (m_valid & m_ready), wraps.

Behaviour:
- Reset (rst=0, async): every output is 0, except s_ready=1 for key words (see ready rules). Internal state clears: word counter wcnt=0, mode=key, assembly register, key register, output register.
- Transfer rules:
  - Input beat = s_valid & s_ready at a rising edge.
  - Output beat = m_valid & m_ready at a rising edge.
- Assembly:
  - wcnt[1:0] counts words of the current group; mode records the s_is_key value of word 0.
  - Word k is stored at bits [127-32k -: 32].
  - On the 4th word, wcnt wraps to 0.
- Ready rules, combinational from registered state and s_is_key:
  - Data word while key_loaded=0 -> s_ready=0 (stall until a key exists).
  - Word 0..2 of any group -> s_ready=1.
  - 4th data word -> s_ready = !m_valid | m_ready.
  - 4th key word -> s_ready = !m_valid | m_ready. The key register is never changed while a block is held.
- Completion:
  - 4th data word accepted at edge N: m_block and m_key (current key register) load at edge N; m_valid=1 from N.
  - Latency is 0 cycles after the final input beat.
  - Output beat and 4th-word acceptance at the same edge: the new block replaces the old, m_valid stays 1, and blk_count still increments.
- Key completion:
  - 4th key word updates the key register and sets key_loaded=1 (sticky until reset).
  - Subsequent blocks use the new key. m_key of an already-held block never changes.
- Output register:
  - Output beat with no new block at the same edge -> m_valid=0. m_block and m_key retain their last value.
  - m_block and m_key are stable while m_valid=1 and m_ready=0.
- Mode mismatch: an input beat with wcnt!=0 and s_is_key != mode:
  - Discard the partial group.
  - The word becomes word 0 of a new group in the new mode.
  - err=1 for the following cycle.
- blk_count increments on every output beat and wraps from 2^CNT_W-1 to 0.
- Reset mid-group or mid-hold: partial group and held block are lost and key_loaded=0. No spurious m_valid after release.

Optional Feature:
- Macro: AES_WORD_BSWAP_EN.
- Defined: each s_data word is byte-reversed before storage (s_data[7:0] lands in the word's MSB byte). This applies to both key and data words, for little-endian bus masters.
- Undefined: words are stored as received. No swap logic is present.

Test Plan:
- Reset release, then key words 2b7e1516,28aed2a6,abf71588,09cf4f3c followed by data words 3243f6a8,885a308d,313198a2,e0370734, m_ready=1 -> m_valid pulses one cycle, m_key=2b7e1516..09cf4f3c, m_block=3243f6a8..e0370734, blk_count=1, key_loaded=1.
- Data words offered before any key -> s_ready=0 for all of them, m_valid stays 0; after the key group, the same words are accepted.
- m_ready=0 with a block held, next 4 data words offered -> words 0-2 accepted, 4th stalls with s_ready=0; m_ready=1 -> 4th accepted at the same edge as the output beat, m_valid stays 1 with the new block, blk_count+1.
- 2 data words then 1 key word -> err pulses for 1 cycle; the partial data is discarded; the key word counts as key word 0.
- New key group arrives while a block is held (m_ready=0) -> m_key of the held block unchanged; 4th key word stalls until the output beat.
- Preset blk_count to all ones (CNT_W=4, 15 blocks), one more block -> blk_count=0.
- Assert rst mid-group (wcnt=2) -> outputs and key_loaded clear immediately.
- With AES_WORD_BSWAP_EN: word 0x00112233 -> stored as 0x33221100.

Source files
------------

// File: rtl/aes_word_loader_if.sv
// Word-stream input / 128-bit block output bundle of aes_word_loader.
// The loader uses the slave modport; the upstream/downstream side uses master.
interface aes_word_loader_if;
  logic [31:0]  s_data;
  logic         s_is_key;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] m_block;
  logic [127:0] m_key;
  logic         m_valid;
  logic         m_ready;

  modport slave (
    input  s_data, s_is_key, s_valid, m_ready,
    output s_ready, m_block, m_key, m_valid
  );

  modport master (
    output s_data, s_is_key, s_valid, m_ready,
    input  s_ready, m_block, m_key, m_valid
  );
endinterface

// File: rtl/aes_word_loader.sv
// Assembles 32-bit key/plaintext words into 128-bit blocks for the AES-128 core.
// Optional AES_WORD_BSWAP_EN: byte-reverse every input word before storage.
module aes_word_loader #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  aes_word_loader_if.slave bus,
  output logic             key_loaded,
  output logic             err,
  output logic [CNT_W-1:0] blk_count
);

  typedef enum logic {MODE_KEY = 1'b0, MODE_DATA = 1'b1} mode_e;

  mode_e            mode_q, mode_d;
  logic [1:0]       wcnt_q, wcnt_d;
  logic [95:0]      asm_q, asm_d;
  logic [127:0]     key_q, key_d;
  logic             key_loaded_q, key_loaded_d;
  logic [127:0]     m_block_q, m_block_d;
  logic [127:0]     m_key_q, m_key_d;
  logic             m_valid_q, m_valid_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] blk_count_q, blk_count_d;

  logic [31:0]  word;
  logic [127:0] full;
  mode_e        in_mode;
  logic         mismatch, last, out_free, out_beat, in_beat, s_ready_c;
  logic [1:0]   idx;

`ifdef AES_WORD_BSWAP_EN
  assign word = {bus.s_data[7:0], bus.s_data[15:8], bus.s_data[23:16], bus.s_data[31:24]};
`else
  assign word = bus.s_data;
`endif

  // A type switch mid-group restarts at word 0, so readiness follows the restarted index.
  assign in_mode  = bus.s_is_key ? MODE_KEY : MODE_DATA;
  assign mismatch = (wcnt_q != 2'd0) && (in_mode != mode_q);
  assign idx      = mismatch ? 2'd0 : wcnt_q;
  assign last     = (idx == 2'd3);
  assign out_free = !m_valid_q || bus.m_ready;
  assign out_beat = m_valid_q && bus.m_ready;
  assign in_beat  = bus.s_valid && s_ready_c;
  assign full     = {asm_q, word};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= MODE_KEY;
      wcnt_q <= '0;
    end else begin
      mode_q <= mode_d;
      wcnt_q <= wcnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    mode_d = mode_q;
    wcnt_d = wcnt_q;
    if (in_beat) begin
      if (idx == 2'd0) mode_d = in_mode;
      wcnt_d = idx + 2'd1;
    end
  end

  // Output logic
  always_comb begin
    s_ready_c = 1'b1;
    if (in_mode == MODE_DATA && !key_loaded_q) s_ready_c = 1'b0;
    else if (last)                             s_ready_c = out_free;
  end

  always_comb begin
    asm_d        = asm_q;
    key_d        = key_q;
    key_loaded_d = key_loaded_q;
    m_block_d    = m_block_q;
    m_key_d      = m_key_q;
    m_valid_d    = m_valid_q;
    err_d        = in_beat && mismatch;
    blk_count_d  = blk_count_q + CNT_W'(out_beat);

    if (out_beat) m_valid_d = 1'b0;

    if (in_beat) begin
      case (idx)
        2'd0:    asm_d[95:64] = word;
        2'd1:    asm_d[63:32] = word;
        2'd2:    asm_d[31:0]  = word;
        default: ;
      endcase
      if (last && in_mode == MODE_KEY) begin
        key_d        = full;
        key_loaded_d = 1'b1;
      end else if (last) begin
        m_block_d = full;
        m_key_d   = key_q;
        m_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      asm_q        <= '0;
      key_q        <= '0;
      key_loaded_q <= 1'b0;
      m_block_q    <= '0;
      m_key_q      <= '0;
      m_valid_q    <= 1'b0;
      err_q        <= 1'b0;
      blk_count_q  <= '0;
    end else begin
      asm_q        <= asm_d;
      key_q        <= key_d;
      key_loaded_q <= key_loaded_d;
      m_block_q    <= m_block_d;
      m_key_q      <= m_key_d;
      m_valid_q    <= m_valid_d;
      err_q        <= err_d;
      blk_count_q  <= blk_count_d;
    end
  end

  assign bus.s_ready = s_ready_c;
  assign bus.m_block = m_block_q;
  assign bus.m_key   = m_key_q;
  assign bus.m_valid = m_valid_q;
  assign key_loaded  = key_loaded_q;
  assign err         = err_q;
  assign blk_count   = blk_count_q;

endmodule

// File: tb/tb_aes_word_loader.sv
// Self-checking bench for aes_word_loader: directed table, corner sequences, random run
// against a queue-based reference model.
module tb_aes_word_loader;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             key_loaded, err;
  logic [CNT_W-1:0] blk_count;

  aes_word_loader_if bus();

  aes_word_loader #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .key_loaded (key_loaded),
    .err        (err),
    .blk_count  (blk_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0]  grp[$];
  bit           grp_key;
  logic [127:0] r_keyreg, r_blk, r_hkey;
  bit           r_have, r_held, r_err;
  int unsigned  r_cnt;
  logic         rdy_seen;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bswap_if_en(input logic [31:0] d);
`ifdef AES_WORD_BSWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  function automatic bit model_ready(input bit k, input bit mr);
    bit mis;
    int n;
    mis = (grp.size() != 0) && (k != grp_key);
    n   = mis ? 0 : grp.size();
    if (!k && !r_have) return 1'b0;
    if (n == 3) return !r_held || mr;
    return 1'b1;
  endfunction

  task automatic model_reset();
    grp.delete();
    grp_key  = 1'b1;
    r_keyreg = '0;
    r_blk    = '0;
    r_hkey   = '0;
    r_have   = 1'b0;
    r_held   = 1'b0;
    r_err    = 1'b0;
    r_cnt    = 0;
  endtask

  task automatic model_edge(input logic [31:0] d, input bit k, input bit beat, input bit mr);
    bit mis;
    logic [127:0] full;
    mis   = (grp.size() != 0) && (k != grp_key);
    r_err = beat && mis;
    if (r_held && mr) begin
      r_cnt  = (r_cnt + 1) % (1 << CNT_W);
      r_held = 1'b0;
    end
    if (beat) begin
      if (mis) grp.delete();
      if (grp.size() == 0) grp_key = k;
      grp.push_back(bswap_if_en(d));
      if (grp.size() == 4) begin
        full = {grp[0], grp[1], grp[2], grp[3]};
        if (grp_key) begin
          r_keyreg = full;
          r_have   = 1'b1;
        end else begin
          r_held = 1'b1;
          r_blk  = full;
          r_hkey = r_keyreg;
        end
        grp.delete();
      end
    end
  endtask

  task automatic check_outputs();
    chk("m_valid",    bus.m_valid, r_held);
    chk("m_block",    bus.m_block, r_blk);
    chk("m_key",      bus.m_key,   r_hkey);
    chk("key_loaded", key_loaded,  r_have);
    chk("err",        err,         r_err);
    chk("blk_count",  blk_count,   r_cnt[CNT_W-1:0]);
  endtask

  // One clock cycle: drive, check combinational ready, advance, check registered outputs.
  task automatic cycle(input logic [31:0] d, input bit k, input bit v, input bit mr);
    bit exp_r;
    bus.s_data   = d;
    bus.s_is_key = k;
    bus.s_valid  = v;
    bus.m_ready  = mr;
    #1;
    exp_r    = model_ready(k, mr);
    rdy_seen = bus.s_ready;
    chk("s_ready", rdy_seen, exp_r);
    @(posedge clk);
    model_edge(d, k, v && exp_r, mr);
    #1;
    check_outputs();
  endtask

  task automatic send(input logic [31:0] w, input bit k, input bit mr);
    cycle(bswap_if_en(w), k, 1'b1, mr);
  endtask

  task automatic idle(input bit mr);
    cycle(32'h0, 1'b0, 1'b0, mr);
  endtask

  task automatic do_reset();
    rst          = 1'b0;
    bus.s_valid  = 1'b0;
    bus.m_ready  = 1'b0;
    bus.s_is_key = 1'b1;
    bus.s_data   = '0;
    model_reset();
    #1;
    chk("rst_ready_key", bus.s_ready, 1'b1);
    bus.s_is_key = 1'b0;
    #1;
    chk("rst_ready_data", bus.s_ready, 1'b0);
    chk("rst_m_valid",    bus.m_valid, 1'b0);
    chk("rst_key_loaded", key_loaded,  1'b0);
    chk("rst_blk_count",  blk_count,   '0);
    chk("rst_m_block",    bus.m_block, '0);
    chk("rst_err",        err,         1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] d;
    bit          k, v, mr;
    bit          e_rdy, e_mv, e_kl;
    logic [3:0]  e_cnt;
  } vec_t;

  localparam logic [127:0] AES_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] AES_PT  = 128'h3243f6a8885a308d313198a2e0370734;

  vec_t        tbl[$];
  logic [31:0] d1[4], d2[4], k2[4];
  bit          rk;

  initial begin
    d1 = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    d2 = '{32'ha0a0a0a0, 32'hb1b1b1b1, 32'hc2c2c2c2, 32'hd3d3d3d3};
    k2 = '{32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'hcafef00d};

    //            d             k  v  mr rdy mv kl cnt
    tbl.push_back('{32'h3243f6a8, 0, 1, 1, 0, 0, 0, 4'd0});
    tbl.push_back('{32'h885a308d, 0, 1, 1, 0, 0, 0, 4'd0});
    tbl.push_back('{32'h2b7e1516, 1, 1, 1, 1, 0, 0, 4'd0});
    tbl.push_back('{32'h28aed2a6, 1, 1, 1, 1, 0, 0, 4'd0});
    tbl.push_back('{32'habf71588, 1, 1, 1, 1, 0, 0, 4'd0});
    tbl.push_back('{32'h09cf4f3c, 1, 1, 1, 1, 0, 1, 4'd0});
    tbl.push_back('{32'h3243f6a8, 0, 1, 1, 1, 0, 1, 4'd0});
    tbl.push_back('{32'h885a308d, 0, 1, 1, 1, 0, 1, 4'd0});
    tbl.push_back('{32'h313198a2, 0, 1, 1, 1, 0, 1, 4'd0});
    tbl.push_back('{32'he0370734, 0, 1, 1, 1, 1, 1, 4'd0});
    tbl.push_back('{32'h00000000, 0, 0, 1, 1, 0, 1, 4'd1});

    do_reset();

    foreach (tbl[i]) begin
      cycle(bswap_if_en(tbl[i].d), tbl[i].k, tbl[i].v, tbl[i].mr);
      chk("tbl_ready",      rdy_seen,    tbl[i].e_rdy);
      chk("tbl_m_valid",    bus.m_valid, tbl[i].e_mv);
      chk("tbl_key_loaded", key_loaded,  tbl[i].e_kl);
      chk("tbl_blk_count",  blk_count,   tbl[i].e_cnt);
    end
    chk("tbl_m_block", bus.m_block, AES_PT);
    chk("tbl_m_key",   bus.m_key,   AES_KEY);

    // Held block, 4th word of the next block stalls until the output beat.
    for (int i = 0; i < 4; i++) send(d1[i], 1'b0, 1'b0);
    chk("hold_m_valid", bus.m_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      send(d2[i], 1'b0, 1'b0);
      chk("hold_w_ready", rdy_seen, 1'b1);
    end
    for (int i = 0; i < 2; i++) begin
      send(d2[3], 1'b0, 1'b0);
      chk("hold_4th_stall", rdy_seen, 1'b0);
      chk("hold_block_stable", bus.m_block, {d1[0], d1[1], d1[2], d1[3]});
    end
    send(d2[3], 1'b0, 1'b1);
    chk("swap_ready",   rdy_seen,    1'b1);
    chk("swap_m_valid", bus.m_valid, 1'b1);
    chk("swap_m_block", bus.m_block, {d2[0], d2[1], d2[2], d2[3]});
    chk("swap_count",   blk_count,   4'd2);

    // Key update while a block is held.
    for (int i = 0; i < 3; i++) send(k2[i], 1'b1, 1'b0);
    send(k2[3], 1'b1, 1'b0);
    chk("keyhold_stall", rdy_seen,  1'b0);
    chk("keyhold_m_key", bus.m_key, AES_KEY);
    send(k2[3], 1'b1, 1'b1);
    chk("keyhold_accept",  rdy_seen,    1'b1);
    chk("keyhold_m_valid", bus.m_valid, 1'b0);
    chk("keyhold_retain",  bus.m_key,   AES_KEY);
    for (int i = 0; i < 4; i++) send(d1[i], 1'b0, 1'b0);
    chk("newkey_m_key", bus.m_key, {k2[0], k2[1], k2[2], k2[3]});
    idle(1'b1);
    chk("newkey_count", blk_count, 4'd4);

    // Type switch mid-group.
    send(d2[0], 1'b0, 1'b1);
    send(d2[1], 1'b0, 1'b1);
    send(d1[0], 1'b1, 1'b1);
    chk("mis_err_pulse", err, 1'b1);
    idle(1'b1);
    chk("mis_err_clear", err, 1'b0);
    for (int i = 1; i < 4; i++) send(d1[i], 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send(d2[i], 1'b0, 1'b0);
    chk("mis_m_key",   bus.m_key,   {d1[0], d1[1], d1[2], d1[3]});
    chk("mis_m_block", bus.m_block, {d2[0], d2[1], d2[2], d2[3]});

    // Reset while a block is held and a group is half assembled.
    send(d1[0], 1'b0, 1'b0);
    send(d1[1], 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 2; i++) begin
      idle(1'b1);
      chk("post_rst_m_valid", bus.m_valid, 1'b0);
    end

    // Counter wrap with a 4-bit counter.
    for (int i = 0; i < 4; i++) send(AES_KEY[127-32*i -: 32], 1'b1, 1'b1);
    for (int b = 0; b < 15; b++)
      for (int i = 0; i < 4; i++) send(d2[i] ^ b, 1'b0, 1'b1);
    idle(1'b1);
    chk("wrap_at_max", blk_count, 4'hf);
    for (int i = 0; i < 4; i++) send(d1[i], 1'b0, 1'b1);
    idle(1'b1);
    chk("wrap_to_zero", blk_count, 4'h0);

`ifdef AES_WORD_BSWAP_EN
    do_reset();
    for (int i = 0; i < 4; i++) cycle(32'h00112233, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cycle(32'h00112233, 1'b0, 1'b1, 1'b0);
    chk("bswap_m_key", bus.m_key, {4{32'h33221100}});
`endif

    // Randomized run against the model.
    do_reset();
    rk = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0) rk = !rk;
      cycle($urandom, rk, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
